// File: rtl/ysyx_24110015_core_sequencer_if.sv
// Handshake bundle between the multicycle sequencer and the IFU/IDU/LSU/WBU/CSR units.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface ysyx_24110015_core_sequencer_if;
  logic       irq;
  logic       ifu_done;
  logic       ifu_err;
  logic       idu_ls;
  logic       idu_store;
  logic       idu_ebreak;
  logic       lsu_done;
  logic       lsu_err;
  logic       ifu_req;
  logic       lsu_req;
  logic       reg_write;
  logic       trap_req;
  logic [4:0] trap_cause;

  modport master (
    input  irq, ifu_done, ifu_err, idu_ls, idu_store, idu_ebreak, lsu_done, lsu_err,
    output ifu_req, lsu_req, reg_write, trap_req, trap_cause
  );

  modport slave (
    output irq, ifu_done, ifu_err, idu_ls, idu_store, idu_ebreak, lsu_done, lsu_err,
    input  ifu_req, lsu_req, reg_write, trap_req, trap_cause
  );
endinterface

// File: rtl/ysyx_24110015_core_sequencer.sv
// Multicycle instruction sequencer: fetch/data start pulses, commit strobe, trap and halt control.
// Optional performance counters are built when YSYX_24110015_SEQ_PERF_EN is defined.
module ysyx_24110015_core_sequencer #(
  parameter int unsigned TMO_W  = 8,
  parameter int unsigned PERF_W = 32
) (
  input  logic                                clock,
  input  logic                                reset,
  ysyx_24110015_core_sequencer_if.master      bus,
  output logic                                halt,
  output logic [2:0]                          state,
  output logic [PERF_W-1:0]                   cyc_cnt,
  output logic [PERF_W-1:0]                   inst_cnt,
  output logic [PERF_W-1:0]                   stall_cnt
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StFetchReq  = 3'd1;
  localparam logic [2:0] StFetchWait = 3'd2;
  localparam logic [2:0] StExec      = 3'd3;
  localparam logic [2:0] StMemReq    = 3'd4;
  localparam logic [2:0] StMemWait   = 3'd5;
  localparam logic [2:0] StWb        = 3'd6;
  localparam logic [2:0] StTrap      = 3'd7;

  localparam logic [4:0] CauseIfu   = 5'h01;
  localparam logic [4:0] CauseLoad  = 5'h05;
  localparam logic [4:0] CauseStore = 5'h07;
  localparam logic [4:0] CauseIrq   = 5'h1B;

  // Count is 0 in the first wait cycle, so this value marks the (2^TMO_W-1)th wait cycle.
  localparam logic [TMO_W-1:0] TmoLast = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [2:0]       state_q, state_d;
  logic             halt_q, halt_d;
  logic             store_q, store_d;
  logic [4:0]       cause_q, cause_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_hit;

  assign tmo_hit = (tmo_q == TmoLast);

  always_comb begin
    state_d = state_q;
    halt_d  = halt_q;
    store_d = store_q;
    cause_d = cause_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      StIdle: begin
        if (!halt_q) state_d = StFetchReq;
      end
      StFetchReq: begin
        state_d = StFetchWait;
        tmo_d   = '0;
      end
      StFetchWait: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.ifu_done && !bus.ifu_err) begin
          state_d = StExec;
        end else if (bus.ifu_done || tmo_hit) begin
          state_d = StTrap;
          cause_d = CauseIfu;
        end
      end
      StExec: begin
        if (bus.idu_ebreak) begin
          halt_d  = 1'b1;
          state_d = StIdle;
        end else if (bus.idu_ls) begin
          store_d = bus.idu_store;
          state_d = StMemReq;
        end else begin
          state_d = StWb;
        end
      end
      StMemReq: begin
        state_d = StMemWait;
        tmo_d   = '0;
      end
      StMemWait: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (bus.lsu_done && !bus.lsu_err) begin
          state_d = StWb;
        end else if (bus.lsu_done || tmo_hit) begin
          state_d = StTrap;
          cause_d = store_q ? CauseStore : CauseLoad;
        end
      end
      StWb: begin
        // Interrupt is taken only after the current instruction has committed.
        if (bus.irq) begin
          state_d = StTrap;
          cause_d = CauseIrq;
        end else begin
          state_d = StFetchReq;
        end
      end
      StTrap: begin
        state_d = StFetchReq;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      halt_q  <= 1'b0;
      store_q <= 1'b0;
      cause_q <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
      store_q <= store_d;
      cause_q <= cause_d;
      tmo_q   <= tmo_d;
    end
  end

  // Strobes decode straight from the state, so they are exclusive and last one cycle.
  assign bus.ifu_req    = (state_q == StFetchReq);
  assign bus.lsu_req    = (state_q == StMemReq);
  assign bus.reg_write  = (state_q == StWb);
  assign bus.trap_req   = (state_q == StTrap);
  assign bus.trap_cause = cause_q;
  assign halt           = halt_q;
  assign state          = state_q;

`ifdef YSYX_24110015_SEQ_PERF_EN
  logic [PERF_W-1:0] cyc_q, inst_q, stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      cyc_q   <= '0;
      inst_q  <= '0;
      stall_q <= '0;
    end else begin
      if (!halt_q && (state_q != StIdle)) cyc_q <= cyc_q + PERF_W'(1);
      if (state_q == StWb) inst_q <= inst_q + PERF_W'(1);
      if ((state_q == StFetchWait) || (state_q == StMemWait)) stall_q <= stall_q + PERF_W'(1);
    end
  end

  assign cyc_cnt   = cyc_q;
  assign inst_cnt  = inst_q;
  assign stall_cnt = stall_q;
`else
  assign cyc_cnt   = '0;
  assign inst_cnt  = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_24110015_core_sequencer.sv
// Directed bench for the core sequencer, built with TMO_W=4 so fetch timeouts are short.
module tb_ysyx_24110015_core_sequencer;
  localparam int unsigned PERF_W = 32;

  logic              clock;
  logic              reset;
  logic              halt;
  logic [2:0]        state;
  logic [PERF_W-1:0] cyc_cnt, inst_cnt, stall_cnt;

  int checks = 0;
  int errors = 0;
  logic saw_bad;

  ysyx_24110015_core_sequencer_if bus_if();

  ysyx_24110015_core_sequencer #(
    .TMO_W  (4),
    .PERF_W (PERF_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus_if),
    .halt      (halt),
    .state     (state),
    .cyc_cnt   (cyc_cnt),
    .inst_cnt  (inst_cnt),
    .stall_cnt (stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_inputs();
    bus_if.irq        = 1'b0;
    bus_if.ifu_done   = 1'b0;
    bus_if.ifu_err    = 1'b0;
    bus_if.idu_ls     = 1'b0;
    bus_if.idu_store  = 1'b0;
    bus_if.idu_ebreak = 1'b0;
    bus_if.lsu_done   = 1'b0;
    bus_if.lsu_err    = 1'b0;
  endtask

  // Leaves the bench in cycle 0 (IDLE, reset low).
  task automatic do_reset();
    reset = 1'b1;
    clr_inputs();
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    clr_inputs();
    do_reset();

    // Reset state
    check("rst_state", 32'(state), 32'd0);
    check("rst_halt", 32'(halt), 32'd0);
    check("rst_ifu_req", 32'(bus_if.ifu_req), 32'd0);
    check("rst_reg_write", 32'(bus_if.reg_write), 32'd0);
    check("rst_trap_req", 32'(bus_if.trap_req), 32'd0);
    check("rst_cause", 32'(bus_if.trap_cause), 32'd0);
    check("rst_cyc_cnt", cyc_cnt, 32'd0);

    // ALU instruction, ifu_done in cycle 3
    cyc(); // 1
    check("alu_ifu_req_c1", 32'(bus_if.ifu_req), 32'd1);
    cyc(); // 2
    check("alu_state_c2", 32'(state), 32'd2);
    check("alu_ifu_req_c2", 32'(bus_if.ifu_req), 32'd0);
    cyc(); // 3
    bus_if.ifu_done = 1'b1;
    check("alu_state_c3", 32'(state), 32'd2);
    cyc(); // 4
    bus_if.ifu_done = 1'b0;
    check("alu_exec_c4", 32'(state), 32'd3);
    check("alu_no_rw_c4", 32'(bus_if.reg_write), 32'd0);
    cyc(); // 5
    check("alu_reg_write_c5", 32'(bus_if.reg_write), 32'd1);
    cyc(); // 6
    check("alu_ifu_req_c6", 32'(bus_if.ifu_req), 32'd1);

    // Load with bus error
    cyc(); // 7 FETCH_WAIT
    bus_if.ifu_done = 1'b1;
    cyc(); // 8 EXEC
    bus_if.ifu_done = 1'b0;
    bus_if.idu_ls   = 1'b1;
    cyc(); // 9 MEM_REQ
    bus_if.idu_ls = 1'b0;
    check("ld_lsu_req", 32'(bus_if.lsu_req), 32'd1);
    cyc(); // 10 MEM_WAIT
    check("ld_mem_wait", 32'(state), 32'd5);
    bus_if.lsu_done = 1'b1;
    bus_if.lsu_err  = 1'b1;
    cyc(); // 11 TRAP
    clr_inputs();
    check("ld_trap_req", 32'(bus_if.trap_req), 32'd1);
    check("ld_trap_cause", 32'(bus_if.trap_cause), 32'h05);
    check("ld_no_reg_write", 32'(bus_if.reg_write), 32'd0);
    cyc(); // 12
    check("ld_refetch", 32'(bus_if.ifu_req), 32'd1);
    check("ld_trap_done", 32'(bus_if.trap_req), 32'd0);

    // Store with bus error
    cyc(); // 13
    bus_if.ifu_done = 1'b1;
    cyc(); // 14 EXEC
    bus_if.ifu_done  = 1'b0;
    bus_if.idu_ls    = 1'b1;
    bus_if.idu_store = 1'b1;
    cyc(); // 15 MEM_REQ
    clr_inputs();
    cyc(); // 16 MEM_WAIT
    bus_if.lsu_done = 1'b1;
    bus_if.lsu_err  = 1'b1;
    cyc(); // 17 TRAP
    clr_inputs();
    check("st_trap_cause", 32'(bus_if.trap_cause), 32'h07);
    cyc(); // 18 FETCH_REQ

    // Interrupt in WB
    cyc(); // 19
    bus_if.ifu_done = 1'b1;
    cyc(); // 20 EXEC
    bus_if.ifu_done = 1'b0;
    cyc(); // 21 WB
    bus_if.irq = 1'b1;
    check("irq_reg_write", 32'(bus_if.reg_write), 32'd1);
    cyc(); // 22 TRAP
    bus_if.irq = 1'b0;
    check("irq_trap_req", 32'(bus_if.trap_req), 32'd1);
    check("irq_cause", 32'(bus_if.trap_cause), 32'h1B);
    check("irq_no_reg_write", 32'(bus_if.reg_write), 32'd0);
    cyc(); // 23
    check("irq_refetch", 32'(bus_if.ifu_req), 32'd1);

    // Fetch timeout: 15 wait cycles without done
    for (int i = 0; i < 15; i++) cyc(); // 38 = 15th wait cycle
    check("tmo_last_wait", 32'(state), 32'd2);
    cyc(); // 39
    check("tmo_trap_req", 32'(bus_if.trap_req), 32'd1);
    check("tmo_cause", 32'(bus_if.trap_cause), 32'h01);
    cyc(); // 40
    check("tmo_refetch", 32'(bus_if.ifu_req), 32'd1);

    // Done on the 15th wait cycle wins over the timeout
    cyc(); // 41 = 1st wait cycle
    for (int i = 0; i < 14; i++) cyc(); // 55 = 15th wait cycle
    bus_if.ifu_done = 1'b1;
    cyc(); // 56
    bus_if.ifu_done = 1'b0;
    check("tmo_done_wins", 32'(state), 32'd3);
    check("tmo_done_no_trap", 32'(bus_if.trap_req), 32'd0);

    // ebreak in EXEC halts
    bus_if.idu_ebreak = 1'b1;
    cyc(); // 57
    bus_if.idu_ebreak = 1'b0;
    check("ebreak_halt", 32'(halt), 32'd1);
    check("ebreak_idle", 32'(state), 32'd0);
    saw_bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (bus_if.ifu_req !== 1'b0 || state !== 3'd0) saw_bad = 1'b1;
    end
    check("halt_no_fetch", 32'(saw_bad), 32'd0);
    check("halt_sticky", 32'(halt), 32'd1);
    do_reset();
    check("reset_clears_halt", 32'(halt), 32'd0);
    cyc(); // 1
    check("resume_fetch", 32'(bus_if.ifu_req), 32'd1);

    // Three ALU instructions with 1-cycle done latency
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(); // FETCH_REQ
      cyc(); // FETCH_WAIT
      bus_if.ifu_done = 1'b1;
      cyc(); // EXEC
      bus_if.ifu_done = 1'b0;
      cyc(); // WB
    end
    cyc(); // 13 FETCH_REQ
    check("perf_state", 32'(state), 32'd1);
`ifdef YSYX_24110015_SEQ_PERF_EN
    check("perf_inst_cnt", inst_cnt, 32'd3);
    check("perf_stall_cnt", stall_cnt, 32'd3);
    check("perf_cyc_cnt", cyc_cnt, 32'd12);
`else
    check("perf_inst_cnt", inst_cnt, 32'd0);
    check("perf_stall_cnt", stall_cnt, 32'd0);
    check("perf_cyc_cnt", cyc_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
